// File: rtl/card_pkg.sv
// card_pkg: FSM states, deck constants and seven-segment glyph tables
package card_pkg;
  typedef enum logic [1:0] {EMPTY, SHOW, FROZEN} state_e;
  localparam int NUM_CARDS = 52;
  localparam int RANKS = 13;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [3:0][6:0] SUIT_LO = {7'b0100100, 7'b0110001, 7'b0110111, 7'b0000001};
  localparam logic [3:0][6:0] SUIT_HI = {7'b0011000, 7'b1001111, 7'b0110000, 7'b1111001};
  localparam logic [15:0][6:0] RANK_LO = {BLANK, BLANK, BLANK,
    7'b1111000, 7'b0000001, 7'b1000111, 7'b1001111, 7'b0000100, 7'b0000000, 7'b0001111,
    7'b0100000, 7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010, 7'b0001000};
  localparam logic [15:0][6:0] RANK_HI = {BLANK, BLANK, BLANK,
    7'b0110111, 7'b1110111, 7'b1111111, 7'b0000001, BLANK, BLANK, BLANK,
    BLANK, BLANK, BLANK, BLANK, BLANK, BLANK};
endpackage

// File: rtl/card_glyph_decode.sv
// card_glyph_decode: card code to four seven-segment digit patterns
module card_glyph_decode
  import card_pkg::*;
(
  input  logic [5:0] code_i,
  output logic [6:0] dig1_o,
  output logic [6:0] dig2_o,
  output logic [6:0] dig3_o,
  output logic [6:0] dig4_o
);
  logic [1:0] suit;
  logic [3:0] rank;
  // split the code into suit and rank, then look up each digit glyph
  always_comb begin
    suit = 2'(code_i / 6'(RANKS));
    rank = 4'(code_i % 6'(RANKS));
    dig1_o = RANK_LO[rank];
    dig2_o = RANK_HI[rank];
    dig3_o = SUIT_LO[suit];
    dig4_o = SUIT_HI[suit];
  end
endmodule

// File: rtl/hand_display_sequencer.sv
// hand_display_sequencer: stores a hand of cards and rotates them onto a 4-digit display
module hand_display_sequencer
  import card_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DWELL = 50000000,
  parameter int MAX_CARDS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          hold,
  input  logic                          card_valid,
  input  logic [5:0]                    card_in,
  output logic                          card_ready,
  output logic                          bad_card,
  output logic [$clog2(MAX_CARDS):0]    count,
  output logic [$clog2(MAX_CARDS)-1:0]  cur_idx,
  output logic [6:0]                    seg,
  output logic [3:0]                    an
);
  localparam int IW = $clog2(MAX_CARDS);
  localparam int CW = IW + 1;
  localparam int DW = $clog2(DWELL);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CARDS);
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] SLAST = SW'(SCAN_DIV - 1);
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0] dig_q, dig_d;
  logic bad_q, bad_d, rdy_q;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [5:0] buf_q [MAX_CARDS];
  logic push, good, dwell_wrap, scan_wrap, blank;
  logic [6:0] d1, d2, d3, d4;
  card_glyph_decode u_dec (
    .code_i (buf_q[cur_idx_q]),
    .dig1_o (d1),
    .dig2_o (d2),
    .dig3_o (d3),
    .dig4_o (d4)
  );
  // rdy_q keeps pushes off until the first edge after reset release
  assign card_ready = rdy_q && (count_q < CMAX) && !clr;
  assign bad_card = bad_q;
  assign count = count_q;
  assign cur_idx = cur_idx_q;
  assign seg = seg_q;
  assign an = an_q;
  // next-state, counters and registered display outputs
  always_comb begin
    push = card_valid && card_ready;
    good = push && (card_in < 6'(NUM_CARDS));
    bad_d = push && !good;
    state_d = clr ? EMPTY
            : (state_q == EMPTY && good) ? SHOW
            : (state_q == SHOW && hold) ? FROZEN
            : (state_q == FROZEN && !hold) ? SHOW : state_q;
    count_d = clr ? '0 : good ? count_q + 1'b1 : count_q;
    dwell_wrap = dwell_q == DLAST;
    dwell_d = clr ? '0 : (state_q != SHOW) ? dwell_q : dwell_wrap ? '0 : dwell_q + 1'b1;
    cur_idx_d = clr ? '0
              : !(state_q == SHOW && dwell_wrap) ? cur_idx_q
              : ({1'b0, cur_idx_q} + 1'b1 >= count_q) ? '0 : cur_idx_q + 1'b1;
    scan_wrap = scan_q == SLAST;
    scan_d = scan_wrap ? '0 : scan_q + 1'b1;
    dig_d = scan_wrap ? dig_q + 1'b1 : dig_q;
    blank = clr || state_q == EMPTY;
    an_d = blank ? 4'b1111 : ~(4'b0001 << dig_q);
    seg_d = blank ? BLANK : (dig_q == 2'd0) ? d1 : (dig_q == 2'd1) ? d2 : (dig_q == 2'd2) ? d3 : d4;
  end
  // state and control registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      cur_idx_q <= '0;
      dwell_q <= '0;
      scan_q <= '0;
      dig_q <= '0;
      bad_q <= 1'b0;
      rdy_q <= 1'b0;
      an_q <= 4'b1111;
      seg_q <= BLANK;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cur_idx_q <= cur_idx_d;
      dwell_q <= dwell_d;
      scan_q <= scan_d;
      dig_q <= dig_d;
      bad_q <= bad_d;
      rdy_q <= 1'b1;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  // hand buffer, written at the current count on each valid push
  always_ff @(posedge clk) begin
    if (good) buf_q[count_q[IW-1:0]] <= card_in;
  end
endmodule

// File: tb/tb_hand_display_sequencer.sv
// tb_hand_display_sequencer: directed checks of push, rotation, hold, clear and reset
module tb_hand_display_sequencer;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, hold = 1'b0, card_valid = 1'b0;
  logic [5:0] card_in = '0;
  logic card_ready, bad_card;
  logic [3:0] count;
  logic [2:0] cur_idx;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0, errors = 0, cyc = 0;
  int t1, t2, t3;

  hand_display_sequencer #(.SCAN_DIV(4), .DWELL(32), .MAX_CARDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hold(hold), .card_valid(card_valid),
    .card_in(card_in), .card_ready(card_ready), .bad_card(bad_card), .count(count),
    .cur_idx(cur_idx), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] code);
    card_valid = 1'b1;
    card_in = code;
    tick();
    card_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] a, input logic [6:0] s);
    for (int i = 0; i < 40 && an !== a; i++) tick();
    chk({tag, "_an"}, an, a);
    chk({tag, "_seg"}, seg, s);
  endtask

  task automatic wait_idx(input string tag, input logic [2:0] idx, output int t);
    for (int i = 0; i < 200 && cur_idx !== idx; i++) tick();
    chk(tag, cur_idx, idx);
    t = cyc;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_idx", cur_idx, 0);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_bad", bad_card, 0);
    chk("rst_ready", card_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", card_ready, 1);

    push(6'd0);
    chk("push0_count", count, 1);
    wait_an("c0_d1", 4'b1110, 7'b0001000);
    wait_an("c0_d2", 4'b1101, 7'b1111111);
    wait_an("c0_d3", 4'b1011, 7'b0000001);
    wait_an("c0_d4", 4'b0111, 7'b1111001);

    do_clr();
    chk("clr_count", count, 0);
    chk("clr_an", an, 4'b1111);
    card_valid = 1'b1;
    card_in = 6'd0;  tick();
    card_in = 6'd14; tick();
    card_in = 6'd51; tick();
    card_valid = 1'b0;
    chk("three_count", count, 3);
    wait_idx("rot_idx1", 3'd1, t1);
    wait_idx("rot_idx2", 3'd2, t2);
    chk("rot_dwell_a", t2 - t1, 32);
    tick();
    wait_an("c51_d1", 4'b1110, 7'b1111000);
    wait_an("c51_d2", 4'b1101, 7'b0110111);
    wait_an("c51_d3", 4'b1011, 7'b0100100);
    wait_an("c51_d4", 4'b0111, 7'b0011000);
    wait_idx("rot_idx0", 3'd0, t3);
    chk("rot_dwell_b", t3 - t2, 32);

    do_clr();
    for (int i = 0; i < 9; i++) begin
      card_valid = 1'b1;
      card_in = 6'(i * 5);
      #1;
      if (i == 7) chk("full_ready_7", card_ready, 1);
      if (i == 8) chk("full_ready_8", card_ready, 0);
      tick();
    end
    card_valid = 1'b0;
    chk("full_count", count, 8);
    wait_an("full_buf0_d1", 4'b1110, 7'b0001000);

    do_clr();
    push(6'd10);
    chk("bad_pre", bad_card, 0);
    push(6'd60);
    chk("bad_pulse", bad_card, 1);
    chk("bad_count", count, 1);
    tick();
    chk("bad_end", bad_card, 0);

    push(6'd20);
    push(6'd30);
    chk("hold_count", count, 3);
    wait_idx("hold_idx1", 3'd1, t1);
    repeat (10) tick();
    hold = 1'b1;
    repeat (100) tick();
    chk("hold_frozen_idx", cur_idx, 1);
    hold = 1'b0;
    wait_idx("hold_idx2", 3'd2, t2);
    chk("hold_resume", t2 - t1, 132);

    clr = 1'b1;
    card_valid = 1'b1;
    card_in = 6'd5;
    #1;
    chk("clr_push_ready", card_ready, 0);
    tick();
    clr = 1'b0;
    card_valid = 1'b0;
    chk("clr_push_count", count, 0);
    chk("clr_push_an", an, 4'b1111);
    chk("clr_push_idx", cur_idx, 0);

    push(6'd1);
    push(6'd2);
    push(6'd3);
    repeat (40) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_idx", cur_idx, 0);
    chk("async_an", an, 4'b1111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_bad", bad_card, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hand_display_sequencer.md
HAND_DISPLAY_SEQUENCER -- requirements
Module: hand_display_sequencer

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit-scan step, minimum 2.
REQ-002 Parameter DWELL, default 50000000: clk cycles each card is shown before rotating, minimum 2.
REQ-003 Parameter MAX_CARDS, default 8: hand buffer depth, power of two, at most 16.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  empty the hand (synchronous, level-sampled).
REQ-007 hold  in  1  freeze rotation while high.
REQ-008 card_valid  in  1  card push request.
REQ-009 card_in  in  6  card code 0..51: suit = code/13, rank = code%13.
REQ-010 card_ready  out  1  push accepted when valid and ready are both high.
REQ-011 bad_card  out  1  one-cycle pulse when an accepted code exceeds 51.
REQ-012 count  out  clog2(MAX_CARDS)+1  number of stored cards.
REQ-013 cur_idx  out  clog2(MAX_CARDS)  buffer index being shown.
REQ-014 seg  out  7  active-low segments, bit6=a through bit0=g.
REQ-015 an  out  4  active-low digit enables; an[0]=dig1 (rank low), an[1]=dig2, an[2]=dig3 (suit), an[3]=dig4.

Function
REQ-016 States: EMPTY, SHOW, FROZEN.
REQ-017 Transitions: EMPTY->SHOW on first valid accepted card; SHOW->FROZEN while hold=1; FROZEN->SHOW when hold=0; any state->EMPTY on clr.
REQ-018 card_ready = (count < MAX_CARDS) and not clr.
REQ-019 Accepted codes 0..51 are written at buffer[count] and count increments the same cycle.
REQ-020 Accepted codes 52..63 are discarded; count is unchanged and bad_card pulses the next cycle.
REQ-021 clr has priority over a same-cycle push: the push is not accepted, count becomes 0, cur_idx becomes 0, and the dwell counter clears.
REQ-022 In SHOW only, the dwell counter counts 0..DWELL-1; at terminal count cur_idx advances, wrapping count-1->0.
REQ-023 count==1: cur_idx stays 0 and the dwell counter still wraps.
REQ-024 A push during SHOW or FROZEN does not alter cur_idx or the dwell counter.
REQ-025 FROZEN holds both the dwell counter and cur_idx.
REQ-026 The scan counter runs in every state; the 2-bit digit select advances 0->1->2->3->0 every SCAN_DIV cycles.
REQ-027 seg and an are registered: one cycle of latency from digit select and cur_idx to the pins.
REQ-028 In EMPTY: an=4'b1111 and seg=7'b1111111.
REQ-029 In SHOW or FROZEN: exactly one an bit is low, and seg carries the glyph for the selected digit of buffer[cur_idx].
REQ-030 Glyphs are taken from card_pkg.
REQ-031 Suit glyphs (dig3/dig4): suit0 0000001/1111001; suit1 0110111/0110000; suit2 0110001/1001111; suit3 0100100/0011000.
REQ-032 Rank glyphs, dig1 (dig2=1111111 unless noted): 0001000, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-033 Rank glyphs, special cases (dig1/dig2): rank9 1001111/0000001; rank10 1000111/1111111; rank11 0000001/1110111; rank12 1111000/0110111.

Reset
REQ-034 rst_n low asynchronously forces: state=EMPTY, count=0, cur_idx=0, dwell and scan counters=0, digit select=0, bad_card=0, an=1111, seg=1111111.
REQ-035 Buffer contents are not reset.
REQ-036 Reset asserted mid-rotation or mid-push discards the hand; no push is accepted in the cycle rst_n deasserts.

Structure
REQ-037 card_pkg holds the state enum, the suit and rank glyph constants, and the constants NUM_CARDS=52 and RANKS=13.
REQ-038 One combinational sub-module, card_glyph_decode (6-bit code in, four 7-bit digit patterns out), is instantiated once on buffer[cur_idx].
REQ-039 Rank/suit extraction SHALL produce 2-bit suit and 4-bit rank values; no 1-bit truncation.

Verification (SCAN_DIV=4, DWELL=32, MAX_CARDS=8)
REQ-040 Reset, then push 0 -> count=1, state SHOW; the scan cycles an 1110,1101,1011,0111 with seg 0001000,1111111,0000001,1111001.
REQ-041 Push 0, 14, 51 -> cur_idx sequence 0,1,2,0 at 32-cycle intervals; for code 51, dig1=1111000, dig2=0110111, dig3=0100100, dig4=0011000.
REQ-042 Push 9 codes back-to-back -> the 9th sees card_ready=0; count=8; buffer[0..7] unchanged.
REQ-043 Push 60 -> accepted, count unchanged, bad_card high for exactly 1 cycle.
REQ-044 hold=1 for 100 cycles mid-dwell -> cur_idx constant; after release the dwell resumes from its held value. clr concurrent with card_valid -> count=0, an=1111 after 1 cycle.
REQ-045 Drop rst_n asynchronously mid-dwell with 3 cards loaded -> outputs at reset values immediately, before the next clk edge.
